// File: rtl/rotate_imm_encoder_pkg.sv
// Shared processor defines for the rotate-immediate encoder: widths, FSM states
// and the rotate-left-by-two helper used by the encoding search.
package rotate_imm_encoder_pkg;

  localparam int DATA_W = 32;
  localparam int ROT_W  = 4;
  localparam int IMM_W  = 8;
  localparam int OP_W   = ROT_W + IMM_W;

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_e;

  function automatic logic [DATA_W-1:0] rotl2(input logic [DATA_W-1:0] v);
    return {v[DATA_W-3:0], v[DATA_W-1:DATA_W-2]};
  endfunction

endpackage

// File: rtl/rotate_imm_encoder.sv
// Encodes a 32-bit constant as an 8-bit immediate rotated right by an even amount,
// or checks it against the 12-bit memory-offset range, one rotation step per cycle.
module rotate_imm_encoder
  import rotate_imm_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem,
  input  logic [DATA_W-1:0] value,
  output logic              ready,
  output logic              done,
  output logic              valid,
  output logic [OP_W-1:0]   shift_operand
);

  state_e            state_q;
  logic [DATA_W-1:0] work_q;
  logic [ROT_W-1:0]  rot_q;
  logic              mem_q;
  logic              done_q;
  logic              valid_q;
  logic [OP_W-1:0]   op_q;

  logic              imm_fit_s;
  logic              ofs_fit_s;

  // Fit checks on the current working value: 8-bit immediate or 12-bit offset.
  always_comb begin
    imm_fit_s = (work_q[DATA_W-1:IMM_W] == {(DATA_W-IMM_W){1'b0}});
    ofs_fit_s = (work_q[DATA_W-1:OP_W] == {(DATA_W-OP_W){1'b0}});
  end

  // Encoder FSM: accept a request in IDLE, step the rotation search in SEARCH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      work_q  <= {DATA_W{1'b0}};
      rot_q   <= {ROT_W{1'b0}};
      mem_q   <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      op_q    <= {OP_W{1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            work_q  <= value;
            rot_q   <= {ROT_W{1'b0}};
            mem_q   <= mem;
            state_q <= SEARCH;
          end
        end
        SEARCH: begin
          if (mem_q) begin
            valid_q <= ofs_fit_s;
            op_q    <= ofs_fit_s ? work_q[OP_W-1:0] : {OP_W{1'b0}};
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (imm_fit_s) begin
            valid_q <= 1'b1;
            op_q    <= {rot_q, work_q[IMM_W-1:0]};
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (rot_q == {ROT_W{1'b1}}) begin
            // Every even rotation tried without a fit: not encodable.
            valid_q <= 1'b0;
            op_q    <= {OP_W{1'b0}};
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            work_q <= rotl2(work_q);
            rot_q  <= rot_q + {{(ROT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready         = (state_q == IDLE);
  assign done          = done_q;
  assign valid         = valid_q;
  assign shift_operand = op_q;

endmodule

// File: tb/tb_rotate_imm_encoder.sv
// Self-checking bench for rotate_imm_encoder: directed corner cases plus
// randomized requests compared against an arithmetic encoding model.
module tb_rotate_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem;
  logic [31:0] value;
  logic        ready;
  logic        done;
  logic        valid;
  logic [11:0] shift_operand;

  int n_checks = 0;
  int n_fail   = 0;

  rotate_imm_encoder dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mem           (mem),
    .value         (value),
    .ready         (ready),
    .done          (done),
    .valid         (valid),
    .shift_operand (shift_operand)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] v, input int k);
    logic [63:0] d;
    d = {v, v} >> k;
    return d[31:0];
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input int k);
    logic [63:0] d;
    d = {v, v} << k;
    return d[63:32];
  endfunction

  // Reference: smallest even rotation whose result fits in 8 bits, or the offset range.
  task automatic model(input logic m, input logic [31:0] v,
                       output int lat, output logic ok, output logic [11:0] so);
    logic [31:0] cand;
    logic [3:0]  r4;
    if (m) begin
      lat = 1;
      ok  = (v < 32'd4096);
      so  = ok ? v[11:0] : 12'd0;
    end else begin
      lat = 16;
      ok  = 1'b0;
      so  = 12'd0;
      for (int r = 0; r < 16; r++) begin
        cand = rotl(v, 2 * r);
        if (!ok && cand < 32'd256 && rotr(cand, 2 * r) == v) begin
          ok  = 1'b1;
          lat = r + 1;
          r4  = 4'(r);
          so  = {r4, cand[7:0]};
        end
      end
    end
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = 0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (lat == 0 && done === 1'b1) lat = i;
      if (lat != 0) break;
    end
  endtask

  task automatic run(input logic m, input logic [31:0] v, input string tag);
    int          exp_lat;
    int          lat;
    logic        exp_ok;
    logic [11:0] exp_so;
    model(m, v, exp_lat, exp_ok, exp_so);
    @(negedge clk);
    start = 1'b1; mem = m; value = v;
    @(posedge clk); #1;
    start = 1'b0; value = $urandom;
    chk({tag, ".busy"}, {31'd0, ready}, 32'd0);
    wait_done(20, lat);
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, exp_ok});
    chk({tag, ".operand"}, {20'd0, shift_operand}, {20'd0, exp_so});
    if (!m && valid === 1'b1)
      chk({tag, ".roundtrip"}, rotr({24'd0, shift_operand[7:0]}, 2 * int'(shift_operand[11:8])), v);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, {31'd0, done}, 32'd0);
    chk({tag, ".hold"}, {19'd0, valid, shift_operand}, {19'd0, exp_ok, exp_so});
  endtask

  initial begin
    int          lat;
    int          sel;
    logic [31:0] v;
    logic [31:0] imm;
    rst = 1'b0; start = 1'b0; mem = 1'b0; value = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.ready", {31'd0, ready}, 32'd1);
    chk("reset.done", {31'd0, done}, 32'd0);
    chk("reset.outs", {19'd0, valid, shift_operand}, 32'd0);
    @(negedge clk); rst = 1'b1;

    run(1'b0, 32'h0000_00FF, "dp_ff");
    run(1'b0, 32'hF000_000F, "dp_f00f");
    run(1'b0, 32'hFF00_0000, "dp_ff00");
    run(1'b0, 32'h0000_0102, "dp_102");
    run(1'b0, 32'h0000_0000, "dp_zero");
    run(1'b1, 32'h0000_0ABC, "mem_abc");
    run(1'b1, 32'h0000_1000, "mem_1000");

    // Second start during the search is ignored; restart in the done cycle is accepted.
    @(negedge clk); start = 1'b1; mem = 1'b0; value = 32'hFF00_0000;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); @(negedge clk); start = 1'b1; value = 32'h0000_0001;
    @(posedge clk); #1; start = 1'b0;
    wait_done(20, lat);
    chk("ignore.latency", lat + 2, 5);
    chk("ignore.operand", {20'd0, shift_operand}, 32'h0000_04FF);
    chk("ignore.valid", {31'd0, valid}, 32'd1);
    chk("ignore.ready", {31'd0, ready}, 32'd1);
    start = 1'b1; value = 32'h0000_00FF;
    @(posedge clk); #1; start = 1'b0;
    chk("restart.busy", {31'd0, ready}, 32'd0);
    chk("restart.pulse", {31'd0, done}, 32'd0);
    wait_done(20, lat);
    chk("restart.latency", lat, 1);
    chk("restart.operand", {20'd0, shift_operand}, 32'h0000_00FF);

    // Reset at E3 of an unencodable search aborts it silently.
    @(negedge clk); start = 1'b1; mem = 1'b0; value = 32'h0000_0102;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    chk("abort.done", {31'd0, done}, 32'd0);
    chk("abort.ready", {31'd0, ready}, 32'd1);
    chk("abort.outs", {19'd0, valid, shift_operand}, 32'd0);
    wait_done(20, lat);
    chk("abort.nopulse", lat, 0);

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: run(1'b0, $urandom, "rnd_dp");
        1: begin
          imm = {24'd0, 8'($urandom_range(0, 255))};
          v   = rotr(imm, 2 * $urandom_range(0, 15));
          run(1'b0, v, "rnd_enc");
        end
        2: run(1'b1, 32'($urandom_range(0, 8191)), "rnd_mem");
        default: run(1'($urandom_range(0, 1)), $urandom, "rnd_any");
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
